// File: rtl/bayes_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bayes_ctrl_pkg
// Shared definitions for the Bayesian inference sequencer:
//   - default geometry (class count, feature limit, vote counter width)
//   - length of the write pulse applied to each stochastic feature
//   - the sequencer state encoding
// ---------------------------------------------------------------------------
package bayes_ctrl_pkg;

    localparam int N_CLASSES = 4;
    localparam int MAX_FEAT  = 8;
    localparam int CNT_W     = 16;

    // Number of cycles the write line is held with the column select dropped.
    localparam int PULSE_LEN = 2;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_SEED,
        F_ADDR,
        F_PRECHARGE,
        F_PULSE,
        F_OFF,
        S_READ,
        S_ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/bayes_vote_counter.sv
// ---------------------------------------------------------------------------
// bayes_vote_counter
// One saturating vote counter per class plus a combinational argmax.
//   clk, rst   : clock, synchronous active-high reset (clears all counters)
//   i_clear    : clear all counters (new inference accepted)
//   i_accum    : add i_bits[c] to counter c this cycle
//   i_bits     : one vote bit per class
//   o_counts   : packed counters, class c at [CNT_W*c +: CNT_W]
//   o_winner   : index of the largest counter, lowest index on ties
// ---------------------------------------------------------------------------
module bayes_vote_counter
    import bayes_ctrl_pkg::*;
#(
    parameter int N_CLASSES = bayes_ctrl_pkg::N_CLASSES,
    parameter int CNT_W     = bayes_ctrl_pkg::CNT_W,
    parameter int WIN_W     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clear,
    input  logic                       i_accum,
    input  logic [N_CLASSES-1:0]       i_bits,
    output logic [CNT_W*N_CLASSES-1:0] o_counts,
    output logic [WIN_W-1:0]           o_winner
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < N_CLASSES; gi++) begin : g_cls
            logic [CNT_W-1:0] r_count;

            always_ff @(posedge clk) begin
                if (rst || i_clear) begin
                    r_count <= '0;
                end else if (i_accum && i_bits[gi] && (r_count != CNT_MAX)) begin
                    r_count <= r_count + CNT_ONE;
                end
            end

            assign o_counts[CNT_W*gi +: CNT_W] = r_count;
        end
    endgenerate

    // Strict greater-than keeps the earliest class on ties; all-zero -> 0.
    logic [CNT_W-1:0] w_best_val;
    logic [WIN_W-1:0] w_best_idx;

    always_comb begin
        w_best_val = o_counts[CNT_W-1:0];
        w_best_idx = '0;
        for (int c = 1; c < N_CLASSES; c++) begin
            if (o_counts[CNT_W*c +: CNT_W] > w_best_val) begin
                w_best_val = o_counts[CNT_W*c +: CNT_W];
                w_best_idx = WIN_W'(c);
            end
        end
    end

    assign o_winner = w_best_idx;

endmodule

// File: rtl/bayes_inference_sequencer.sv
// ---------------------------------------------------------------------------
// bayes_inference_sequencer
// Drives a stochastic Bayesian-inference memory chip: loads the RNG seed,
// then for every sample writes each observed feature with an address /
// precharge / pulse / off sequence, reads the per-class bits back and
// accumulates them into saturating vote counters.
//   clk, rst           : clock, synchronous active-high reset
//   start              : launch request, honoured only when idle
//   seed_value         : RNG seed pattern (captured at start)
//   n_samples          : number of samples (captured at start)
//   n_features         : features per sample, clamped to 1..MAX_FEAT
//   obs                : 6-bit observation per feature, feature f at [6f+:6]
//   busy, done         : status; done is a one-cycle completion pulse
//   counts, winner     : per-class vote totals and their argmax
//   CSL..stoch_log     : chip control strobes (Moore decode of state)
//   seeds, adr_full_*  : chip seed bus and feature address
//   bit_out            : per-class sample bits, valid the cycle after read_1
//   CBL..read_out      : unused chip controls, tied low
// ---------------------------------------------------------------------------
module bayes_inference_sequencer
    import bayes_ctrl_pkg::*;
#(
    parameter int N_CLASSES = bayes_ctrl_pkg::N_CLASSES,
    parameter int MAX_FEAT  = bayes_ctrl_pkg::MAX_FEAT,
    parameter int CNT_W     = bayes_ctrl_pkg::CNT_W,
    localparam int WIN_W    = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 seed_value,
    input  logic [CNT_W-1:0]           n_samples,
    input  logic [3:0]                 n_features,
    input  logic [6*MAX_FEAT-1:0]      obs,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W*N_CLASSES-1:0] counts,
    output logic [WIN_W-1:0]           winner,
    output logic                       CSL,
    output logic                       CWL,
    output logic                       inference,
    output logic                       load_seed,
    output logic                       read_1,
    output logic                       stoch_log,
    output logic [7:0]                 seeds,
    output logic [7:0]                 adr_full_col,
    output logic [7:0]                 adr_full_row,
    input  logic [N_CLASSES-1:0]       bit_out,
    output logic                       CBL,
    output logic                       CBLEN,
    output logic                       read_8,
    output logic                       load_mem,
    output logic                       read_out
);

    localparam logic [3:0]       MAX_FEAT_L = 4'(MAX_FEAT);
    localparam int               FIDX_W     = (MAX_FEAT > 1) ? $clog2(MAX_FEAT) : 1;
    localparam logic             PULSE_LAST = 1'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] SMP_ONE    = CNT_W'(1);
    localparam logic [CNT_W:0]   SMP_ONE_X  = (CNT_W+1)'(1);

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0]      r_n_samples;
    logic [CNT_W-1:0]      r_sample_idx;
    logic [3:0]            r_n_feat;
    logic [3:0]            r_feat_idx;
    logic                  r_pulse_cnt;
    logic [6*MAX_FEAT-1:0] r_obs;
    logic [7:0]            r_seed;

    logic       w_accept;
    logic       w_accum;
    logic       w_feat_last;
    logic       w_sample_last;
    logic [3:0] w_feat_clamp;
    logic [7:0] w_row;
    logic [7:0] w_col;
    logic [5:0] w_obs_feat [MAX_FEAT];

    assign w_accept = (r_state == IDLE) && start;
    assign w_accum  = (r_state == S_ACCUM);

    // "Another feature/sample follows" is idx+1 < limit; widened so the
    // sample comparison cannot wrap at the top of the counter range.
    assign w_feat_last   = ((r_feat_idx + 4'd1) >= r_n_feat);
    assign w_sample_last = (({1'b0, r_sample_idx} + SMP_ONE_X) >= {1'b0, r_n_samples});

    always_comb begin
        w_feat_clamp = n_features;
        if (n_features == 4'd0) begin
            w_feat_clamp = 4'd1;
        end else if (n_features > MAX_FEAT_L) begin
            w_feat_clamp = MAX_FEAT_L;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_FEAT; gi++) begin : g_obs
            assign w_obs_feat[gi] = r_obs[6*gi +: 6];
        end
    endgenerate

    // Addresses come from captured observations and the registered feature
    // index, so the chip bus never sees the live obs input.
    assign w_row = {2'b00, w_obs_feat[r_feat_idx[FIDX_W-1:0]]};
    assign w_col = {r_feat_idx[2:0], 5'b0_0000};

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next state and Moore outputs ----------------
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != IDLE);
        done         = 1'b0;
        CSL          = 1'b0;
        CWL          = 1'b0;
        inference    = 1'b0;
        load_seed    = 1'b0;
        read_1       = 1'b0;
        stoch_log    = 1'b0;
        seeds        = 8'h00;
        adr_full_col = 8'h00;
        adr_full_row = 8'h00;

        case (r_state)
            IDLE: begin
                if (start) w_state_next = LOAD_SEED;
            end
            LOAD_SEED: begin
                load_seed    = 1'b1;
                seeds        = r_seed;
                w_state_next = (r_n_samples == '0) ? DONE : F_ADDR;
            end
            F_ADDR: begin
                stoch_log    = 1'b1;
                adr_full_row = w_row;
                adr_full_col = w_col;
                w_state_next = F_PRECHARGE;
            end
            F_PRECHARGE: begin
                stoch_log    = 1'b1;
                CSL          = 1'b1;
                CWL          = 1'b1;
                adr_full_row = w_row;
                adr_full_col = w_col;
                w_state_next = F_PULSE;
            end
            F_PULSE: begin
                stoch_log    = 1'b1;
                CWL          = 1'b1;
                adr_full_row = w_row;
                adr_full_col = w_col;
                if (r_pulse_cnt == PULSE_LAST) w_state_next = F_OFF;
            end
            F_OFF: begin
                stoch_log    = 1'b1;
                inference    = 1'b1;
                adr_full_row = w_row;
                adr_full_col = w_col;
                w_state_next = w_feat_last ? S_READ : F_ADDR;
            end
            S_READ: begin
                stoch_log    = 1'b1;
                read_1       = 1'b1;
                w_state_next = S_ACCUM;
            end
            S_ACCUM: begin
                w_state_next = w_sample_last ? DONE : F_ADDR;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ---------------- configuration capture and loop counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_samples  <= '0;
            r_n_feat     <= '0;
            r_obs        <= '0;
            r_seed       <= '0;
            r_feat_idx   <= '0;
            r_sample_idx <= '0;
            r_pulse_cnt  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n_samples  <= n_samples;
                        r_n_feat     <= w_feat_clamp;
                        r_obs        <= obs;
                        r_seed       <= seed_value;
                        r_feat_idx   <= '0;
                        r_sample_idx <= '0;
                    end
                end
                F_PRECHARGE: r_pulse_cnt <= 1'b0;
                F_PULSE:     r_pulse_cnt <= r_pulse_cnt + 1'b1;
                F_OFF:       r_feat_idx  <= w_feat_last ? 4'd0 : (r_feat_idx + 4'd1);
                S_ACCUM:     r_sample_idx <= r_sample_idx + SMP_ONE;
                default: ;
            endcase
        end
    end

    bayes_vote_counter #(
        .N_CLASSES (N_CLASSES),
        .CNT_W     (CNT_W),
        .WIN_W     (WIN_W)
    ) u_votes (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_accept),
        .i_accum  (w_accum),
        .i_bits   (bit_out),
        .o_counts (counts),
        .o_winner (winner)
    );

    assign CBL      = 1'b0;
    assign CBLEN    = 1'b0;
    assign read_8   = 1'b0;
    assign load_mem = 1'b0;
    assign read_out = 1'b0;

endmodule

// File: tb/tb_bayes_inference_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bayes_inference_sequencer
// Directed and randomized transactions against a behavioural model of the
// sequencer: latency from the closed-form formula, vote totals from the
// bits the chip model returns after each read_1, and address sequence from
// the captured observations. A narrow vote-counter instance covers
// saturation directly.
// ---------------------------------------------------------------------------
module tb_bayes_inference_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  seed_value;
    logic [15:0] n_samples;
    logic [3:0]  n_features;
    logic [47:0] obs;
    logic        busy, done;
    logic [63:0] counts;
    logic [1:0]  winner;
    logic        CSL, CWL, inference, load_seed, read_1, stoch_log;
    logic [7:0]  seeds, adr_full_col, adr_full_row;
    logic [3:0]  bit_out;
    logic        CBL, CBLEN, read_8, load_mem, read_out;

    logic        v_clear, v_accum;
    logic [3:0]  v_bits;
    logic [15:0] v_counts;
    logic [1:0]  v_winner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bayes_inference_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .seed_value(seed_value),
        .n_samples(n_samples), .n_features(n_features), .obs(obs),
        .busy(busy), .done(done), .counts(counts), .winner(winner),
        .CSL(CSL), .CWL(CWL), .inference(inference), .load_seed(load_seed),
        .read_1(read_1), .stoch_log(stoch_log), .seeds(seeds),
        .adr_full_col(adr_full_col), .adr_full_row(adr_full_row),
        .bit_out(bit_out), .CBL(CBL), .CBLEN(CBLEN), .read_8(read_8),
        .load_mem(load_mem), .read_out(read_out)
    );

    bayes_vote_counter #(.N_CLASSES(4), .CNT_W(4), .WIN_W(2)) u_vc (
        .clk(clk), .rst(rst), .i_clear(v_clear), .i_accum(v_accum),
        .i_bits(v_bits), .o_counts(v_counts), .o_winner(v_winner)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // First index holding the maximum value.
    function automatic int argmax(input int v [4]);
        int best = 0;
        for (int i = 1; i < 4; i++) if (v[i] > v[best]) best = i;
        return best;
    endfunction

    task automatic run_txn(input string tag, input int n, input int nf, input logic [47:0] ob,
                           input logic [7:0] sd, input bit fixed, input logic [3:0] fixed_bits,
                           input bit hold);
        int f_eff, exp_lat, lat, n_busy, n_seed, n_read, n_addr, n_inf, n_cwl;
        int n_hold, n_const, extra_done, fi;
        int acc [4];
        logic [3:0]  v;
        logic [63:0] exp_cnt;
        f_eff   = (nf == 0) ? 1 : ((nf > 8) ? 8 : nf);
        exp_lat = (n == 0) ? 2 : 2 + n * (5 * f_eff + 2);
        lat = 0; n_busy = 0; n_seed = 0; n_read = 0; n_addr = 0; n_inf = 0; n_cwl = 0;
        n_hold = 0; n_const = 0; extra_done = 0;
        acc = '{0, 0, 0, 0};

        @(negedge clk);
        start = 1'b1; n_samples = 16'(n); n_features = 4'(nf); obs = ob; seed_value = sd;
        for (int k = 1; k <= 600 && lat == 0; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (k == 1) begin
                obs        = 48'({$urandom(), $urandom()});
                n_samples  = 16'($urandom());
                n_features = 4'($urandom());
                seed_value = 8'($urandom());
            end
            if (busy) n_busy++;
            if (CBL | CBLEN | read_8 | load_mem | read_out) n_const++;
            if (load_seed) begin
                n_seed++;
                check({tag, ".seeds"}, 64'(seeds), 64'(sd));
            end
            if (stoch_log && !CSL && !CWL && !inference && !read_1) begin
                fi = n_addr % f_eff;
                check({tag, ".row"}, 64'(adr_full_row), 64'(ob[6*fi +: 6]));
                check({tag, ".col"}, 64'(adr_full_col), 64'(fi * 32));
                n_addr++;
            end
            if (inference) n_inf++;
            if (CWL) n_cwl++;
            if (read_1) begin
                n_read++;
                v = fixed ? fixed_bits : 4'($urandom());
                bit_out = v;
                n_hold = 1;
                for (int c = 0; c < 4; c++) acc[c] += int'(v[c]);
            end else if (n_hold > 0) begin
                n_hold--;
            end else begin
                bit_out = 4'($urandom());
            end
            if (done) lat = k;
        end
        start = 1'b0;

        exp_cnt = '0;
        for (int c = 0; c < 4; c++) exp_cnt[16*c +: 16] = 16'(acc[c]);
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".busy_cycles"}, 64'(n_busy), 64'(exp_lat));
        check({tag, ".seed_pulses"}, 64'(n_seed), 64'(1));
        check({tag, ".reads"}, 64'(n_read), 64'(n));
        check({tag, ".addr_cycles"}, 64'(n_addr), 64'(n * f_eff));
        check({tag, ".inference"}, 64'(n_inf), 64'(n * f_eff));
        check({tag, ".cwl_cycles"}, 64'(n_cwl), 64'(3 * n * f_eff));
        check({tag, ".const_ctrl"}, 64'(n_const), 64'(0));
        check({tag, ".counts"}, counts, exp_cnt);
        check({tag, ".winner"}, 64'(winner), 64'(argmax(acc)));

        @(negedge clk);
        check({tag, ".idle_busy"}, 64'(busy), 64'(0));
        repeat (3) begin
            if (done) extra_done++;
            @(negedge clk);
        end
        check({tag, ".extra_done"}, 64'(extra_done), 64'(0));
        check({tag, ".counts_held"}, counts, exp_cnt);
        $display("txn %s: n=%0d f=%0d latency=%0d counts=%h winner=%0d",
                 tag, n, f_eff, lat, counts, winner);
    endtask

    initial begin
        int found, n_rd;
        int vacc [4];
        logic [15:0] vexp;

        rst = 1'b1; start = 1'b0; seed_value = '0; n_samples = '0; n_features = '0;
        obs = '0; bit_out = '0; v_clear = 1'b0; v_accum = 1'b0; v_bits = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.done", 64'(done), 64'(0));
        check("reset.counts", counts, 64'(0));
        check("reset.winner", 64'(winner), 64'(0));
        check("reset.ctrl", 64'({CSL, CWL, inference, load_seed, read_1, stoch_log}), 64'(0));
        check("reset.bus", 64'({seeds, adr_full_col, adr_full_row}), 64'(0));
        check("reset.vc_counts", 64'(v_counts), 64'(0));
        rst = 1'b0;

        // Single sample, single feature, class 2 votes
        run_txn("basic", 1, 1, 48'h0000_0000_0015, 8'hA5, 1'b1, 4'b0100, 1'b0);
        // Tie between classes 0 and 3 resolves to 0
        run_txn("tie", 3, 2, 48'({$urandom(), $urandom()}), 8'h3C, 1'b1, 4'b1001, 1'b0);
        // Zero samples
        run_txn("zero", 0, 3, 48'({$urandom(), $urandom()}), 8'h5A, 1'b0, 4'h0, 1'b0);
        // start held high, n_features=0 clamps to 1
        run_txn("hold", 2, 0, 48'({$urandom(), $urandom()}), 8'hC3, 1'b0, 4'h0, 1'b1);
        // n_features above the limit clamps to 8
        run_txn("clamp", 2, 15, 48'({$urandom(), $urandom()}), 8'h81, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("rnd%0d", i), int'($urandom_range(1, 5)), int'($urandom_range(0, 15)),
                    48'({$urandom(), $urandom()}), 8'($urandom()), 1'b0, 4'h0, 1'b0);
        end

        // Reset during the write pulse of the second sample
        @(negedge clk);
        start = 1'b1; n_samples = 16'd3; n_features = 4'd2;
        obs = 48'({$urandom(), $urandom()}); bit_out = 4'hF;
        found = 0; n_rd = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (read_1) n_rd++;
            if (n_rd == 1 && stoch_log && CWL && !CSL) found = 1;
        end
        check("midrst.found_pulse", 64'(found), 64'(1));
        check("midrst.pre_counts", counts, 64'h0001_0001_0001_0001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.busy", 64'(busy), 64'(0));
        check("midrst.cwl", 64'(CWL), 64'(0));
        check("midrst.stoch", 64'(stoch_log), 64'(0));
        check("midrst.counts", counts, 64'(0));
        check("midrst.done", 64'(done), 64'(0));
        $display("txn midrst: reset applied during sample 2 pulse, busy=%0d counts=%h", busy, counts);
        run_txn("after_rst", 2, 3, 48'({$urandom(), $urandom()}), 8'h77, 1'b0, 4'h0, 1'b0);

        // Saturation on a 4-bit vote counter; class 1 votes every accumulate
        @(negedge clk);
        v_clear = 1'b1;
        @(negedge clk);
        v_clear = 1'b0;
        vacc = '{0, 0, 0, 0};
        for (int i = 0; i < 24; i++) begin
            v_accum = ($urandom_range(0, 3) != 0);
            v_bits  = 4'($urandom()) | 4'b0010;
            if (v_accum) for (int c = 0; c < 4; c++) vacc[c] += int'(v_bits[c]);
            @(negedge clk);
        end
        v_accum = 1'b0; v_bits = 4'hF;
        @(negedge clk);
        vexp = '0;
        for (int c = 0; c < 4; c++) begin
            if (vacc[c] > 15) vacc[c] = 15;
            vexp[4*c +: 4] = 4'(vacc[c]);
        end
        check("sat.counts", 64'(v_counts), 64'(vexp));
        check("sat.class1", 64'(v_counts[7:4]), 64'(15));
        check("sat.winner", 64'(v_winner), 64'(argmax(vacc)));
        $display("txn sat: counts=%h winner=%0d", v_counts, v_winner);
        v_clear = 1'b1;
        @(negedge clk);
        v_clear = 1'b0;
        check("sat.clear", 64'(v_counts), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bayes_inference_sequencer.md
BAYES_INFERENCE_SEQUENCER -- requirements
Module: bayes_inference_sequencer

Interface
REQ-001 Parameter: N_CLASSES, 4, number of classes (width of chip bit_out).
REQ-002 Parameter: MAX_FEAT, 8, maximum observed features per inference.
REQ-003 Parameter: CNT_W, 16, per-class vote counter width.
REQ-004 Port: clk  in  1  single clock; all logic on posedge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: start  in  1  launch request; sampled only in IDLE.
REQ-007 Port: seed_value  in  8  seed pattern loaded into chip RNGs.
REQ-008 Port: n_samples  in  CNT_W  stochastic samples to run; captured at start.
REQ-009 Port: n_features  in  4  features per sample; captured at start.
REQ-010 Port: obs  in  6*MAX_FEAT  observation value per feature, 6-bit slice f at [6f+:6]; captured at start.
REQ-011 Port: busy  out  1  high in every state except IDLE.
REQ-012 Port: done  out  1  one-cycle pulse on completion.
REQ-013 Port: counts  out  CNT_W*N_CLASSES  per-class vote totals, class c at [CNT_W*c+:CNT_W].
REQ-014 Port: winner  out  2  argmax of counts; ties resolve to lowest index.
REQ-015 Ports to chip: CSL, CWL, inference, load_seed, read_1, stoch_log (out, 1 each); seeds (out 8); adr_full_col, adr_full_row (out 8 each); bit_out (in N_CLASSES); CBL, CBLEN, read_8, load_mem, read_out driven constant 0.

Function
REQ-016 States: IDLE, LOAD_SEED, F_ADDR, F_PRECHARGE, F_PULSE, F_OFF, S_READ, S_ACCUM, DONE.
REQ-017 IDLE: start=1 -> capture n_samples, n_features, obs; clear counts; go LOAD_SEED; start while busy ignored.
REQ-018 n_features clamped: 0 -> 1, >MAX_FEAT -> MAX_FEAT.
REQ-019 LOAD_SEED (1 cycle): load_seed=1, seeds=seed_value; next F_ADDR with f=0, or DONE if n_samples=0.
REQ-020 F_ADDR (1 cycle): stoch_log=1, adr_full_row={2'b00, obs[f]}, adr_full_col={f[2:0], 5'b0}.
REQ-021 F_PRECHARGE (1 cycle): CSL=1, CWL=1, addresses held.
REQ-022 F_PULSE (exactly 2 cycles, internal 1-bit counter): CSL=0, CWL=1.
REQ-023 F_OFF (1 cycle): CWL=0, inference=1; next F_ADDR with f+1 if f+1<n_features, else S_READ.
REQ-024 S_READ (1 cycle): read_1=1, stoch_log=1; bit_out valid in following cycle.
REQ-025 S_ACCUM (1 cycle): counts[c] += bit_out[c], saturating at 2^CNT_W-1; sample counter +1; next F_ADDR (f=0) if samples remain, else DONE.
REQ-026 DONE (1 cycle): done=1; next IDLE; counts and winner held until next accepted start.
REQ-027 stoch_log=1 in F_* and S_READ states; all other chip controls 0 outside the states naming them.
REQ-028 Chip controls are Moore decode of registered state only; no input-to-output combinational path.
REQ-029 Latency: start at cycle t -> done at t+2+N*(5F+2) (F clamped); N=0 -> done at t+2.
REQ-030 winner updates combinationally from counts; all-zero counts -> winner=0.

Reset
REQ-031 rst=1 at any clock edge, including mid-sample: state IDLE, busy=0, done=0, counts=0, all chip control/address/seed outputs 0, captured config cleared.
REQ-032 First start is accepted in the cycle after rst deasserts.

Structure
REQ-033 Package bayes_ctrl_pkg holds the state enum, N_CLASSES, MAX_FEAT, CNT_W and the pulse-length constant (2).
REQ-034 Sub-module bayes_vote_counter holds the saturating counter array, clear/accumulate controls and argmax.

Verification
REQ-035 N=1, F=1, obs[0]=6'h15, bit_out=4'b0100 -> done at t+9, counts={0,1,0,0}, winner=2, row=8'h15 in F_ADDR.
REQ-036 N=3, F=2, bit_out=4'b1001 each sample -> done at t+38, counts[0]=counts[3]=3, winner=0 (tie).
REQ-037 n_samples=0 -> load_seed pulse at t+1, done at t+2, counts all 0.
REQ-038 Preload counts[1]=16'hFFFE, then N=3 with bit_out[1]=1 -> counts[1]=16'hFFFF (saturated).
REQ-039 rst asserted during F_PULSE of sample 2 -> next cycle IDLE, CWL=0, counts=0; new start runs normally.
REQ-040 start held high through a run, n_features=0 -> treated as F=1, exactly one done pulse per accepted start.
